seg7_scan_ctrl: RTL and testbench
=================================

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 SHALL have parameter N_DIGITS, default 4, number of multiplexed digits (2..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 50000, clock cycles each digit is lit per slot (>=1).
REQ-003 SHALL have parameter DEAD_CYCLES, default 2, all-off cycles between slots (>=0).
REQ-004 SHALL have port clk, input, 1, single clock, rising edge.
REQ-005 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-006 SHALL have port load, input, 1, request to capture bcd_in.
REQ-007 SHALL have port bcd_in, input, 4*N_DIGITS, packed BCD value; nibble 0 is the least significant digit.
REQ-008 SHALL have port lz_blank, input, 1, leading-zero blanking enable.
REQ-009 SHALL have port ready, output, 1, high when load is accepted.
REQ-010 SHALL have port dec_bcd, output, 4, digit code driven to the shared BCD_7Seg decoder.
REQ-011 SHALL have port dec_seg, input, 7, decoder result, active-low segments.
REQ-012 SHALL have port seg, output, 7, registered segment drive, active-low; 7'h7F = blank.
REQ-013 SHALL have port digit_en, output, N_DIGITS, registered one-cold digit enables, active-low.
REQ-014 SHALL have port bcd_err, output, 1, one-cycle pulse per slot showing a nibble >9.

Function
REQ-015 SHALL implement states IDLE, SCAN, DEAD.
REQ-016 IDLE: digit_en all 1, seg 7'h7F, ready 1; accepted load copies bcd_in straight into the active register; next state SCAN, slot 0.
REQ-017 SCAN slot k lasts REFRESH_DIV cycles; dec_bcd = active nibble k, combinational from state registers.
REQ-018 Outputs are registered: digit_en and seg reflect slot k one cycle after SCAN entry and hold for REFRESH_DIV cycles.
REQ-019 While lit: digit_en bit k = 0, all other bits = 1; seg = dec_seg sampled while dec_bcd = nibble k.
REQ-020 After SCAN: DEAD for DEAD_CYCLES with digit_en all 1 and seg 7'h7F; if DEAD_CYCLES=0, go directly to the next SCAN slot.
REQ-021 Slot order 0,1,...,N_DIGITS-1, wrapping to 0; the frame boundary is the transition into slot 0.
REQ-022 A nibble >9 SHALL give seg 7'h7F and keep digit_en bit k = 0; bcd_err pulses high on that slot's first output cycle.
REQ-023 With lz_blank=1, zero nibbles above the most significant nonzero nibble SHALL be blanked: seg 7'h7F, digit_en all 1 for that slot. Nibble 0 is never blanked.
REQ-024 Outside IDLE, load with ready=1 SHALL capture bcd_in into a shadow register; ready drops to 0 on the next cycle.
REQ-025 A pending shadow SHALL transfer to the active register at the next frame boundary; ready returns to 1 that same cycle; no mid-frame tearing.
REQ-026 Load while ready=0 SHALL be ignored; the shadow is unchanged.
REQ-027 Load coincident with the frame boundary while ready=1 SHALL be captured and applied at the following boundary.
REQ-028 lz_blank SHALL be sampled continuously; a change takes effect at the next slot.
REQ-029 Once in SCAN, the block never returns to IDLE except by reset.

Reset
REQ-030 On rst=1, asynchronously: state IDLE, slot 0, cycle counters 0, active and shadow registers 0, ready 1, dec_bcd 0, seg 7'h7F, digit_en all 1, bcd_err 0.
REQ-031 Reset mid-scan SHALL force the REQ-030 output values with no clock edge required; any pending load is discarded.

Verification (N_DIGITS=4, REFRESH_DIV=4, DEAD_CYCLES=1)
REQ-032 Reset: assert rst, no clock -> seg=7'h7F, digit_en=4'b1111, ready=1, bcd_err=0.
REQ-033 Basic scan: load 16'h1234 from IDLE -> seg=7'd25 with digit_en=4'b1110 for 4 cycles; then 1 cycle of 4'b1111/7'h7F; then seg=7'd48 with 4'b1101; then 7'd36 with 4'b1011; then 7'd121 with 4'b0111; then repeat.
REQ-034 Invalid digit: load 16'h00A0 -> slot 1 shows seg=7'h7F, digit_en=4'b1101, one bcd_err pulse per frame; slot 0 shows 7'd64.
REQ-035 Leading-zero blanking: lz_blank=1, load 16'h0070 -> slots 3 and 2 have digit_en=4'b1111; slot 1 shows 7'd120; slot 0 shows 7'd64.
REQ-036 Mid-frame load: while showing 16'h1234, load 16'h5678 during slot 1 -> ready=0 until the next frame boundary; slots 2 and 3 still show 2 and 1; the next slot 0 shows 7'd0 (digit 8).
REQ-037 Async reset during slot 2 -> outputs reach REQ-030 values immediately; after release the block sits in IDLE until a load.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - multiplexed 7-segment scan controller driving a shared BCD decoder
// Double-buffered display value, dead time between digits, leading-zero blanking.
module seg7_scan_ctrl #(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] bcd_in,
  input  logic                  lz_blank,
  output logic                  ready,
  output logic [3:0]            dec_bcd,
  input  logic [6:0]            dec_seg,
  output logic [6:0]            seg,
  output logic [N_DIGITS-1:0]   digit_en,
  output logic                  bcd_err
);

  localparam int SLOT_W    = $clog2(N_DIGITS);
  localparam int CNT_MAX   = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int DEAD_LAST = (DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0;

  localparam logic [SLOT_W-1:0]   LAST_SLOT = SLOT_W'(N_DIGITS - 1);
  localparam logic [CNT_W-1:0]    SCAN_END  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]    DEAD_END  = CNT_W'(DEAD_LAST);
  localparam logic [N_DIGITS-1:0] DIGIT0    = N_DIGITS'(1);
  localparam logic [6:0]          BLANK     = 7'h7F;

  typedef enum logic [1:0] {IDLE, SCAN, DEAD} state_t;

  state_t                state, state_nxt;
  logic [SLOT_W-1:0]     slot, slot_nxt, slot_inc;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [4*N_DIGITS-1:0] active, shadow, active_shr;
  logic                  pending;
  logic                  lz_cur;
  logic                  slot_start, frame_start;
  logic [3:0]            nib;
  logic                  upper_zero, lz_hide;
  logic [6:0]            seg_nxt;
  logic [N_DIGITS-1:0]   den_nxt;
  logic                  err_nxt;

  assign slot_inc   = (slot == LAST_SLOT) ? '0 : slot + 1'b1;
  assign active_shr = active >> {slot, 2'b00};
  assign nib        = active_shr[3:0];
  assign dec_bcd    = nib;
  assign ready      = ~pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      slot  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      slot  <= slot_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    slot_nxt   = slot;
    cnt_nxt    = cnt;
    slot_start = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          state_nxt  = SCAN;
          slot_nxt   = '0;
          cnt_nxt    = '0;
          slot_start = 1'b1;
        end
      end
      SCAN: begin
        if (cnt == SCAN_END) begin
          cnt_nxt = '0;
          if (DEAD_CYCLES == 0) begin
            slot_nxt   = slot_inc;
            slot_start = 1'b1;
          end else begin
            state_nxt = DEAD;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DEAD: begin
        if (cnt == DEAD_END) begin
          state_nxt  = SCAN;
          slot_nxt   = slot_inc;
          cnt_nxt    = '0;
          slot_start = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    frame_start = slot_start && (state != IDLE) && (slot_nxt == '0);
  end

  // A slot is leading-zero if it and every more significant nibble are zero.
  always_comb begin
    upper_zero = 1'b1;
    for (int j = 0; j < N_DIGITS; j++) begin
      if ((j >= int'(slot)) && (active[4*j +: 4] != 4'd0)) upper_zero = 1'b0;
    end
  end

  assign lz_hide = lz_cur && upper_zero && (slot != '0);

  always_comb begin
    seg_nxt = BLANK;
    den_nxt = '1;
    err_nxt = 1'b0;
    if ((state == SCAN) && !lz_hide) begin
      den_nxt = ~(DIGIT0 << slot);
      if (nib > 4'd9) err_nxt = (cnt == '0);
      else            seg_nxt = dec_seg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active   <= '0;
      shadow   <= '0;
      pending  <= 1'b0;
      lz_cur   <= 1'b0;
      seg      <= BLANK;
      digit_en <= '1;
      bcd_err  <= 1'b0;
    end else begin
      seg      <= seg_nxt;
      digit_en <= den_nxt;
      bcd_err  <= err_nxt;
      if (slot_start) lz_cur <= lz_blank;
      if (state == IDLE) begin
        if (load) active <= bcd_in;
      end else begin
        // Shadow swaps only on the frame boundary so a frame never mixes two values.
        if (frame_start && pending) begin
          active  <= shadow;
          pending <= 1'b0;
        end
        if (load && !pending) begin
          shadow  <= bcd_in;
          pending <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - directed self-checking bench for seg7_scan_ctrl
module tb_seg7_scan_ctrl;
  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        clk_run = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic [15:0] bcd_in = 16'h0;
  logic        lz_blank = 1'b0;
  logic        ready;
  logic [3:0]  dec_bcd;
  logic [6:0]  dec_seg;
  logic [6:0]  seg;
  logic [3:0]  digit_en;
  logic        bcd_err;

  int n_checks = 0;
  int n_errors = 0;

  seg7_scan_ctrl #(.N_DIGITS(4), .REFRESH_DIV(RD), .DEAD_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .load(load), .bcd_in(bcd_in), .lz_blank(lz_blank),
    .ready(ready), .dec_bcd(dec_bcd), .dec_seg(dec_seg), .seg(seg),
    .digit_en(digit_en), .bcd_err(bcd_err)
  );

  always #5 if (clk_run) clk = ~clk;

  // External decoder, active-low gfedcba; codes >9 give a non-blank pattern.
  always_comb begin
    case (dec_bcd)
      4'd0: dec_seg = 7'h40;
      4'd1: dec_seg = 7'h79;
      4'd2: dec_seg = 7'h24;
      4'd3: dec_seg = 7'h30;
      4'd4: dec_seg = 7'h19;
      4'd5: dec_seg = 7'h12;
      4'd6: dec_seg = 7'h02;
      4'd7: dec_seg = 7'h78;
      4'd8: dec_seg = 7'h00;
      4'd9: dec_seg = 7'h10;
      default: dec_seg = 7'h06;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a slot's first output sample; consumes the lit window and the dead cycle.
  task automatic check_slot(input string tag, input logic [6:0] e_seg, input logic [3:0] e_den,
                            input logic e_err, input logic e_rdy, input int ld_at,
                            input logic [15:0] ld_val, input logic lz_next);
    for (int i = 0; i < RD; i++) begin
      if (i == 0) begin
        check({tag, ".seg0"}, 32'(seg), 32'(e_seg));
        check({tag, ".den0"}, 32'(digit_en), 32'(e_den));
        check({tag, ".err0"}, 32'(bcd_err), 32'(e_err));
      end
      if (i == 1) check({tag, ".err1"}, 32'(bcd_err), 32'd0);
      if (i == RD - 1) begin
        check({tag, ".segN"}, 32'(seg), 32'(e_seg));
        check({tag, ".denN"}, 32'(digit_en), 32'(e_den));
        check({tag, ".rdy"}, 32'(ready), 32'(e_rdy));
      end
      if (i == 0 && ld_at == 1) begin
        load = 1'b1;
        bcd_in = ld_val;
      end
      step(1);
      load = 1'b0;
    end
    check({tag, ".dseg"}, 32'(seg), 32'h7F);
    check({tag, ".dden"}, 32'(digit_en), 32'hF);
    lz_blank = lz_next;
    if (ld_at == 2) begin
      load = 1'b1;
      bcd_in = ld_val;
    end
    step(1);
    load = 1'b0;
  endtask

  initial begin
    #5 rst = 1'b1;
    #1;
    check("rst.seg", 32'(seg), 32'h7F);
    check("rst.den", 32'(digit_en), 32'hF);
    check("rst.rdy", 32'(ready), 32'd1);
    check("rst.err", 32'(bcd_err), 32'd0);
    check("rst.dec", 32'(dec_bcd), 32'd0);
    #4 rst = 1'b0;
    clk_run = 1'b1;
    step(3);
    check("idle.seg", 32'(seg), 32'h7F);
    check("idle.den", 32'(digit_en), 32'hF);
    check("idle.rdy", 32'(ready), 32'd1);

    load = 1'b1;
    bcd_in = 16'h1234;
    step(1);
    load = 1'b0;
    check("ld.dec", 32'(dec_bcd), 32'd4);
    check("ld.rdy", 32'(ready), 32'd1);
    step(1);

    check_slot("f1s0", 7'd25,  4'b1110, 1'b0, 1'b1, 0, 16'h0, 1'b0);
    check_slot("f1s1", 7'd48,  4'b1101, 1'b0, 1'b1, 0, 16'h0, 1'b0);
    check_slot("f1s2", 7'd36,  4'b1011, 1'b0, 1'b1, 0, 16'h0, 1'b0);
    check_slot("f1s3", 7'd121, 4'b0111, 1'b0, 1'b1, 0, 16'h0, 1'b0);
    check_slot("f2s0", 7'd25,  4'b1110, 1'b0, 1'b1, 0, 16'h0, 1'b0);
    check_slot("f2s1", 7'd48,  4'b1101, 1'b0, 1'b0, 1, 16'h5678, 1'b0);
    check_slot("f2s2", 7'd36,  4'b1011, 1'b0, 1'b0, 1, 16'h9999, 1'b0);
    check_slot("f2s3", 7'd121, 4'b0111, 1'b0, 1'b0, 0, 16'h0, 1'b0);
    check_slot("f3s0", 7'd0,   4'b1110, 1'b0, 1'b1, 0, 16'h0, 1'b0);
    check_slot("f3s1", 7'd120, 4'b1101, 1'b0, 1'b1, 0, 16'h0, 1'b0);
    check_slot("f3s2", 7'd2,   4'b1011, 1'b0, 1'b1, 0, 16'h0, 1'b0);
    check_slot("f3s3", 7'd18,  4'b0111, 1'b0, 1'b1, 2, 16'h4321, 1'b0);
    check_slot("f4s0", 7'd0,   4'b1110, 1'b0, 1'b0, 0, 16'h0, 1'b0);
    check_slot("f4s1", 7'd120, 4'b1101, 1'b0, 1'b0, 0, 16'h0, 1'b0);
    check_slot("f4s2", 7'd2,   4'b1011, 1'b0, 1'b0, 0, 16'h0, 1'b0);
    check_slot("f4s3", 7'd18,  4'b0111, 1'b0, 1'b0, 0, 16'h0, 1'b0);
    check_slot("f5s0", 7'd121, 4'b1110, 1'b0, 1'b1, 0, 16'h0, 1'b0);
    check_slot("f5s1", 7'd36,  4'b1101, 1'b0, 1'b0, 1, 16'h9876, 1'b0);

    check("f5s2.seg", 32'(seg), 32'd48);
    check("f5s2.den", 32'(digit_en), 32'b1011);
    #2 rst = 1'b1;
    #1;
    check("mrst.seg", 32'(seg), 32'h7F);
    check("mrst.den", 32'(digit_en), 32'hF);
    check("mrst.rdy", 32'(ready), 32'd1);
    check("mrst.err", 32'(bcd_err), 32'd0);
    check("mrst.dec", 32'(dec_bcd), 32'd0);
    step(1);
    rst = 1'b0;
    step(3);
    check("post.seg", 32'(seg), 32'h7F);
    check("post.den", 32'(digit_en), 32'hF);
    check("post.rdy", 32'(ready), 32'd1);
    check("post.dec", 32'(dec_bcd), 32'd0);

    load = 1'b1;
    bcd_in = 16'h00A0;
    step(1);
    load = 1'b0;
    step(1);
    check_slot("f6s0", 7'd64,  4'b1110, 1'b0, 1'b1, 0, 16'h0, 1'b0);
    check_slot("f6s1", 7'h7F,  4'b1101, 1'b1, 1'b1, 0, 16'h0, 1'b0);
    check_slot("f6s2", 7'd64,  4'b1011, 1'b0, 1'b1, 0, 16'h0, 1'b0);
    check_slot("f6s3", 7'd64,  4'b0111, 1'b0, 1'b1, 0, 16'h0, 1'b0);
    check_slot("f7s0", 7'd64,  4'b1110, 1'b0, 1'b0, 1, 16'h0070, 1'b0);
    check_slot("f7s1", 7'h7F,  4'b1101, 1'b1, 1'b0, 0, 16'h0, 1'b0);
    check_slot("f7s2", 7'd64,  4'b1011, 1'b0, 1'b0, 0, 16'h0, 1'b0);
    check_slot("f7s3", 7'd64,  4'b0111, 1'b0, 1'b0, 0, 16'h0, 1'b1);
    check_slot("f8s0", 7'd64,  4'b1110, 1'b0, 1'b1, 0, 16'h0, 1'b1);
    check_slot("f8s1", 7'd120, 4'b1101, 1'b0, 1'b1, 0, 16'h0, 1'b1);
    check_slot("f8s2", 7'h7F,  4'b1111, 1'b0, 1'b1, 0, 16'h0, 1'b1);
    check_slot("f8s3", 7'h7F,  4'b1111, 1'b0, 1'b1, 0, 16'h0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
